apb3_eg_slave_if: RTL and testbench

APB3 slave protocol front-end for the example-slave register file. Sits directly upstream of the register block. Converts APB3 SETUP/ACCESS phases into a single-cycle register request (addr, read_en, write_en, wdata) and registers the returned rdata onto prdata. Inserts a parameterised number of wait states via pready and flags address-decode errors via pslverr.

---
 rtl/apb3_eg_pkg.sv | 7 +
 rtl/apb3_eg_addr_decode.sv | 10 +
 rtl/apb3_eg_slave_if.sv | 73 +++++++
 tb/tb_apb3_eg_slave_if.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/apb3_eg_pkg.sv
// apb3_eg_pkg: shared FSM encoding and address-map constants for the APB3 example slave
package apb3_eg_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, REQ, RESP} state_t;
  localparam logic [7:0] DATA_HI = 8'h00;
  localparam logic [5:0] ID_HI = 6'h3F;
  localparam int WS_W = 4;
endpackage

// File: rtl/apb3_eg_addr_decode.sv
// apb3_eg_addr_decode: flags accesses outside the data region (reads may also hit the read-only ID region)
module apb3_eg_addr_decode
  import apb3_eg_pkg::*;
(
  input  logic [7:0] paddr_hi,
  input  logic       pwrite,
  output logic       err
);
  assign err = (paddr_hi != DATA_HI) & (pwrite | (paddr_hi[7:2] != ID_HI));
endmodule

// File: rtl/apb3_eg_slave_if.sv
// apb3_eg_slave_if: APB3 slave front-end turning SETUP/ACCESS into a one-cycle register request
module apb3_eg_slave_if
  import apb3_eg_pkg::*;
#(
  parameter int ADDRWIDTH   = 12,
  parameter int WAIT_CYCLES = 0,
  parameter int ERR_EN      = 1
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [ADDRWIDTH-1:0] paddr,
  input  logic [31:0]          pwdata,
  output logic [31:0]          prdata,
  output logic                 pready,
  output logic                 pslverr,
  output logic [ADDRWIDTH-1:0] addr,
  output logic                 read_en,
  output logic                 write_en,
  output logic [31:0]          wdata,
  input  logic [31:0]          rdata
);
  state_t state, state_nx;
  logic [WS_W-1:0] cnt;
  logic wr_q, err_q, dec_err, setup, req_done;
  assign setup = psel & ~penable;
  assign req_done = (state == REQ) & psel;
  apb3_eg_addr_decode u_dec (
    .paddr_hi(paddr[11:4]),
    .pwrite  (pwrite),
    .err     (dec_err)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = setup ? ((WAIT_CYCLES > 0) ? WAIT : REQ) : IDLE;
      WAIT: state_nx = !psel ? IDLE : ((cnt == WS_W'(1)) ? REQ : WAIT);
      REQ:  state_nx = psel ? RESP : IDLE;
      default: state_nx = IDLE;
    endcase
    read_en  = (state == REQ) & ~wr_q & ~err_q;
    write_en = (state == REQ) & wr_q & ~err_q;
  end
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state   <= IDLE;
      cnt     <= '0;
      addr    <= '0;
      wdata   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      prdata  <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && setup) begin
        addr  <= paddr;
        wdata <= pwdata;
        wr_q  <= pwrite;
        err_q <= dec_err;
        cnt   <= WS_W'(WAIT_CYCLES);
      end
      if (state == WAIT) cnt <= cnt - 1'b1;
      // an aborted REQ still strobes but never completes on the bus
      pready  <= req_done;
      pslverr <= req_done & err_q & (ERR_EN != 0);
      prdata  <= (req_done & read_en) ? rdata : '0;
    end
  end
endmodule

// File: tb/tb_apb3_eg_slave_if.sv
// tb_apb3_eg_slave_if: three slave configurations driven by APB transfers and checked against a behavioural memory model
module tb_apb3_eg_slave_if;
  logic pclk = 1'b0, presetn = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic psel[3], penable[3], pready[3], pslverr[3], read_en[3], write_en[3];
  logic [31:0] prdata[3], wdata[3], rdata[3];
  logic [11:0] addr[3];
  logic [31:0] regs[3][4];
  logic [31:0] exp_mem[3][4];
  int tests = 0, fails = 0;
  int o_lat, o_nrd, o_nwr, o_strb;
  logic [31:0] o_rd;
  logic o_err, o_both, o_after;

  always #5 pclk = ~pclk;

  apb3_eg_slave_if #(.ADDRWIDTH(12), .WAIT_CYCLES(0), .ERR_EN(1)) dut0 (
    .pclk(pclk), .presetn(presetn), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0]),
    .addr(addr[0]), .read_en(read_en[0]), .write_en(write_en[0]), .wdata(wdata[0]), .rdata(rdata[0]));
  apb3_eg_slave_if #(.ADDRWIDTH(12), .WAIT_CYCLES(3), .ERR_EN(1)) dut1 (
    .pclk(pclk), .presetn(presetn), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1]),
    .addr(addr[1]), .read_en(read_en[1]), .write_en(write_en[1]), .wdata(wdata[1]), .rdata(rdata[1]));
  apb3_eg_slave_if #(.ADDRWIDTH(12), .WAIT_CYCLES(4), .ERR_EN(0)) dut2 (
    .pclk(pclk), .presetn(presetn), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata[2]), .pready(pready[2]), .pslverr(pslverr[2]),
    .addr(addr[2]), .read_en(read_en[2]), .write_en(write_en[2]), .wdata(wdata[2]), .rdata(rdata[2]));

  // register block stand-in: four data words plus an address-derived ID region
  always_comb
    for (int k = 0; k < 3; k++)
      rdata[k] = (addr[k][11:4] == 8'h00) ? regs[k][addr[k][3:2]] :
                 (addr[k][11:6] == 6'h3F) ? {20'hC0DE0, addr[k]} : 32'hBAD0BAD0;

  always @(posedge pclk)
    for (int k = 0; k < 3; k++)
      if (!presetn) for (int j = 0; j < 4; j++) regs[k][j] <= '0;
      else if (write_en[k]) regs[k][addr[k][3:2]] <= wdata[k];

  function automatic int wc(int k);
    return (k == 0) ? 0 : (k == 1) ? 3 : 4;
  endfunction

  function automatic bit err_en(int k);
    return k != 2;
  endfunction

  function automatic bit is_err(bit wr, logic [11:0] a);
    bit in_data = a[11:4] == 8'h00;
    bit in_id = a[11:6] == 6'h3F;
    return wr ? !in_data : !(in_data || in_id);
  endfunction

  function automatic logic [31:0] exp_rd(int k, logic [11:0] a);
    return (a[11:4] == 8'h00) ? exp_mem[k][a[3:2]] : {20'hC0DE0, a};
  endfunction

  task automatic clear_mem();
    for (int k = 0; k < 3; k++) for (int j = 0; j < 4; j++) exp_mem[k][j] = '0;
  endtask

  // one APB transfer; bus signals are scrambled after SETUP, drop_at>0 releases psel at that ACCESS cycle
  task automatic xfer(input int k, input bit wr, input logic [11:0] a, input logic [31:0] d, input int drop_at);
    o_lat = 0; o_nrd = 0; o_nwr = 0; o_strb = 0; o_both = 0; o_rd = '0; o_err = 0; o_after = 0;
    @(negedge pclk);
    psel[k] = 1; penable[k] = 0; pwrite = wr; paddr = a; pwdata = d;
    for (int n = 1; n <= 40; n++) begin
      @(negedge pclk);
      if (read_en[k]) begin o_nrd++; o_strb = n; end
      if (write_en[k]) begin o_nwr++; o_strb = n; end
      if (read_en[k] && write_en[k]) o_both = 1;
      if (pready[k]) begin o_lat = n; o_rd = prdata[k]; o_err = pslverr[k]; break; end
      if (n == drop_at) psel[k] = 0;
      penable[k] = psel[k]; pwrite = 1'($urandom); paddr = 12'($urandom); pwdata = $urandom;
    end
    psel[k] = 0; penable[k] = 0;
    if (o_lat > 0) begin @(negedge pclk); o_after = pready[k]; end
  endtask

  task automatic test_reset();
    presetn = 0;
    repeat (2) @(negedge pclk);
    for (int k = 0; k < 3; k++) begin
      tests++; if ({pready[k], pslverr[k], read_en[k], write_en[k]} !== 4'b0) begin fails++; $display("FAIL reset_ctl[%0d]: got %b exp 0000", k, {pready[k], pslverr[k], read_en[k], write_en[k]}); end
      tests++; if (prdata[k] !== 32'h0) begin fails++; $display("FAIL reset_prdata[%0d]: got %h exp 0", k, prdata[k]); end
      tests++; if (addr[k] !== 12'h0) begin fails++; $display("FAIL reset_addr[%0d]: got %h exp 0", k, addr[k]); end
      tests++; if (wdata[k] !== 32'h0) begin fails++; $display("FAIL reset_wdata[%0d]: got %h exp 0", k, wdata[k]); end
    end
    presetn = 1;
    clear_mem();
  endtask

  task automatic test_write_read();
    xfer(0, 1, 12'h000, 32'hDEADBEEF, 0);
    exp_mem[0][0] = 32'hDEADBEEF;
    tests++; if (o_lat !== 2) begin fails++; $display("FAIL w0_write_lat: got %0d exp 2", o_lat); end
    tests++; if (o_nwr !== 1 || o_nrd !== 0 || o_strb !== 1) begin fails++; $display("FAIL w0_write_strobe: got nwr=%0d nrd=%0d at %0d exp 1/0 at 1", o_nwr, o_nrd, o_strb); end
    tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL w0_write_err: got %b exp 0", o_err); end
    tests++; if (o_after !== 1'b0) begin fails++; $display("FAIL w0_pready_one_cycle: got %b exp 0", o_after); end
    xfer(0, 0, 12'h000, 32'h0, 0);
    tests++; if (o_rd !== 32'hDEADBEEF) begin fails++; $display("FAIL w0_readback: got %h exp deadbeef", o_rd); end
    tests++; if (o_nrd !== 1 || o_strb !== 1) begin fails++; $display("FAIL w0_read_strobe: got %0d at %0d exp 1 at 1", o_nrd, o_strb); end
  endtask

  task automatic test_wait_states();
    logic [31:0] v = $urandom;
    xfer(1, 1, 12'h00C, v, 0);
    exp_mem[1][3] = v;
    xfer(1, 0, 12'h00C, 32'h0, 0);
    tests++; if (o_lat !== 5) begin fails++; $display("FAIL w3_lat: got %0d exp 5", o_lat); end
    tests++; if (o_nrd !== 1 || o_strb !== 4) begin fails++; $display("FAIL w3_read_strobe: got %0d at %0d exp 1 at 4", o_nrd, o_strb); end
    tests++; if (o_rd !== v) begin fails++; $display("FAIL w3_rdata: got %h exp %h", o_rd, v); end
  endtask

  task automatic test_id_region();
    xfer(0, 1, 12'hFE0, 32'h12345678, 0);
    tests++; if (o_nwr !== 0) begin fails++; $display("FAIL id_write_strobe: got %0d exp 0", o_nwr); end
    tests++; if (o_lat !== 2 || o_err !== 1'b1) begin fails++; $display("FAIL id_write_err: got lat=%0d err=%b exp 2/1", o_lat, o_err); end
    xfer(0, 0, 12'hFE0, 32'h0, 0);
    tests++; if (o_rd !== 32'hC0DE0FE0 || o_err !== 1'b0) begin fails++; $display("FAIL id_read: got %h err=%b exp c0de0fe0/0", o_rd, o_err); end
  endtask

  task automatic test_decode_err();
    xfer(0, 0, 12'h800, 32'h0, 0);
    tests++; if (o_err !== 1'b1 || o_rd !== 32'h0 || o_nrd !== 0) begin fails++; $display("FAIL err_read_en1: got err=%b rd=%h nrd=%0d exp 1/0/0", o_err, o_rd, o_nrd); end
    xfer(2, 0, 12'h800, 32'h0, 0);
    tests++; if (o_lat !== 6 || o_err !== 1'b0 || o_rd !== 32'h0 || o_nrd !== 0) begin fails++; $display("FAIL err_read_en0: got lat=%0d err=%b rd=%h nrd=%0d exp 6/0/0/0", o_lat, o_err, o_rd, o_nrd); end
  endtask

  task automatic test_abort();
    logic [31:0] v = $urandom;
    xfer(2, 1, 12'h004, v, 2);
    tests++; if (o_lat !== 0 || o_nwr !== 0) begin fails++; $display("FAIL abort_wait: got lat=%0d nwr=%0d exp 0/0", o_lat, o_nwr); end
    xfer(2, 0, 12'h004, 32'h0, 0);
    tests++; if (o_lat !== 6 || o_rd !== exp_mem[2][1]) begin fails++; $display("FAIL abort_next: got lat=%0d rd=%h exp 6/%h", o_lat, o_rd, exp_mem[2][1]); end
    xfer(0, 1, 12'h008, v, 1);
    exp_mem[0][2] = v;
    tests++; if (o_lat !== 0 || o_nwr !== 1) begin fails++; $display("FAIL abort_req: got lat=%0d nwr=%0d exp 0/1", o_lat, o_nwr); end
    xfer(0, 0, 12'h008, 32'h0, 0);
    tests++; if (o_rd !== v) begin fails++; $display("FAIL abort_req_commit: got %h exp %h", o_rd, v); end
  endtask

  task automatic test_reset_mid();
    xfer(1, 1, 12'h004, 32'hA5A5A5A5, 0);
    @(negedge pclk);
    psel[1] = 1; penable[1] = 0; pwrite = 0; paddr = 12'h004;
    repeat (2) begin @(negedge pclk); penable[1] = 1; end
    presetn = 0; psel[1] = 0; penable[1] = 0;
    @(negedge pclk);
    tests++; if ({pready[1], pslverr[1], read_en[1], write_en[1]} !== 4'b0 || prdata[1] !== 32'h0 || addr[1] !== 12'h0 || wdata[1] !== 32'h0) begin
      fails++; $display("FAIL midreset_outputs: got ctl=%b prdata=%h addr=%h wdata=%h exp all 0", {pready[1], pslverr[1], read_en[1], write_en[1]}, prdata[1], addr[1], wdata[1]);
    end
    presetn = 1;
    clear_mem();
    xfer(1, 0, 12'h004, 32'h0, 0);
    tests++; if (o_lat !== 5 || o_rd !== 32'h0) begin fails++; $display("FAIL midreset_read: got lat=%0d rd=%h exp 5/0", o_lat, o_rd); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int k = $urandom_range(0, 2);
      bit wr = 1'($urandom);
      logic [31:0] d = $urandom;
      logic [11:0] a = 12'($urandom);
      int sel = $urandom_range(0, 3);
      bit e;
      logic [31:0] er;
      if (sel < 2) a = {8'h00, a[3:0]};
      else if (sel == 2) a = {6'h3F, a[5:0]};
      e = is_err(wr, a);
      er = (!wr && !e) ? exp_rd(k, a) : 32'h0;
      xfer(k, wr, a, d, 0);
      tests++;
      if (o_lat !== wc(k) + 2 || o_err !== (e & err_en(k)) || o_rd !== er || o_nrd !== int'(!wr && !e) ||
          o_nwr !== int'(wr && !e) || (!e && o_strb !== o_lat - 1) || o_both || o_after) begin
        fails++;
        $display("FAIL rand[%0d] k=%0d wr=%b a=%h: got lat=%0d err=%b rd=%h nrd=%0d nwr=%0d strb=%0d after=%b exp lat=%0d err=%b rd=%h",
                 i, k, wr, a, o_lat, o_err, o_rd, o_nrd, o_nwr, o_strb, o_after, wc(k) + 2, e & err_en(k), er);
      end
      if (wr && !e) exp_mem[k][a[3:2]] = d;
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin psel[k] = 0; penable[k] = 0; end
    test_reset();
    test_write_read();
    test_wait_states();
    test_id_region();
    test_decode_err();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
